// File: rtl/sd_spi_card_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : sd_spi_card_responder_if
//  Description : Bundle of the SPI pins, decoded-command outputs and the
//                backing-store byte fetch bus of the SD SPI card responder.
//                master = host / system side, slave = card responder.
//  Ports       : sd_spi_clk/cs/mosi (host->card, async), sd_spi_miso
//                (card->host), card_ready, cmd_valid, cmd_index, cmd_arg,
//                rd_sec_addr, rd_req, rd_byte_idx (card->store), rd_data
//                (store->card, valid 1 cycle after rd_req).
//  Revision    : 1.0 - initial release
// ============================================================================
interface sd_spi_card_responder_if;
  logic        sd_spi_clk;
  logic        sd_spi_cs;
  logic        sd_spi_mosi;
  logic        sd_spi_miso;
  logic        card_ready;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [31:0] rd_sec_addr;
  logic        rd_req;
  logic [8:0]  rd_byte_idx;
  logic [7:0]  rd_data;

  modport master (
    output sd_spi_clk, sd_spi_cs, sd_spi_mosi, rd_data,
    input  sd_spi_miso, card_ready, cmd_valid, cmd_index, cmd_arg,
           rd_sec_addr, rd_req, rd_byte_idx
  );

  modport slave (
    input  sd_spi_clk, sd_spi_cs, sd_spi_mosi, rd_data,
    output sd_spi_miso, card_ready, cmd_valid, cmd_index, cmd_arg,
           rd_sec_addr, rd_req, rd_byte_idx
  );
endinterface
`default_nettype wire

// File: rtl/sd_spi_card_responder.sv
`default_nettype none
// ============================================================================
//  Module      : sd_spi_card_responder
//  Description : Card side of an SD SPI-mode link. Oversamples SCK/CS/MOSI in
//                clk_sd, decodes 48-bit command frames, answers with R1/R3/R7
//                and serves CMD17 single-block reads from a byte-wide store.
//  Ports       : clk_sd  - sole clock
//                reset_n - synchronous active-low reset
//                bus     - slave side of sd_spi_card_responder_if
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_spi_card_responder #(
  parameter int          IDLE_POLLS = 2,
  parameter logic [31:0] OCR        = 32'hC0FF8000
) (
  input  logic                          clk_sd,
  input  logic                          reset_n,
  sd_spi_card_responder_if.slave        bus
);

  typedef enum logic [2:0] {
    ST_HUNT  = 3'd0,
    ST_CMD   = 3'd1,
    ST_RESP  = 3'd2,
    ST_TOKEN = 3'd3,
    ST_DATA  = 3'd4,
    ST_CRC   = 3'd5
  } state_t;

  localparam logic [7:0] c_idle_polls = 8'(IDLE_POLLS);

  // ---------------- input synchronisers and SCK edge detect -----------------
  logic [1:0] r_sck_s, r_cs_s, r_mosi_s;
  logic       r_sck_d;

  always_ff @(posedge clk_sd) begin
    if (!reset_n) begin
      r_sck_s  <= 2'b00;
      r_cs_s   <= 2'b11;
      r_mosi_s <= 2'b11;
      r_sck_d  <= 1'b0;
    end else begin
      r_sck_s  <= {r_sck_s[0],  bus.sd_spi_clk};
      r_cs_s   <= {r_cs_s[0],   bus.sd_spi_cs};
      r_mosi_s <= {r_mosi_s[0], bus.sd_spi_mosi};
      r_sck_d  <= r_sck_s[1];
    end
  end

  logic w_sck_rise, w_sck_fall, w_cs_high, w_mosi;
  assign w_sck_rise = r_sck_s[1] & ~r_sck_d;
  assign w_sck_fall = ~r_sck_s[1] & r_sck_d;
  assign w_cs_high  = r_cs_s[1];
  assign w_mosi     = r_mosi_s[1];

  // ---------------- state ---------------------------------------------------
  state_t          r_state;
  logic [47:0]     r_rx_sr;
  logic [7:0]      r_tx_sr;
  logic [5:0]      r_bit_cnt;     // frame bit count in CMD, bit-in-byte in TX
  logic [8:0]      r_byte_cnt;    // data byte currently being loaded
  logic [7:0][7:0] r_q;           // response queue, entry 0 is the Ncr filler
  logic [2:0]      r_q_len;
  logic [2:0]      r_q_idx;       // queue pointer, reused as CRC byte count
  logic            r_is_read;
  logic            r_card_ready;
  logic            r_app;
  logic [7:0]      r_poll;
  logic            r_frame_done;
  logic            r_cmd_valid;
  logic [5:0]      r_cmd_index;
  logic [31:0]     r_cmd_arg;
  logic [31:0]     r_rd_sec_addr;
  logic            r_rd_req;
  logic            r_rd_req_d;
  logic [8:0]      r_rd_byte_idx;
  logic [7:0]      r_hold;

  // Complete frame as it stands on the 48th rising edge.
  logic [47:0] w_frame;
  logic [5:0]  w_cmd_idx;
  logic [31:0] w_cmd_arg;
  assign w_frame   = {r_rx_sr[46:0], w_mosi};
  assign w_cmd_idx = w_frame[45:40];
  assign w_cmd_arg = w_frame[39:8];

  // ---------------- response builder ---------------------------------------
  logic [7:0]      w_r1;
  logic [7:0][7:0] w_q;
  logic [2:0]      w_q_len;
  logic            w_is_read, w_set_ready, w_clr_ready;
  logic            w_poll_inc, w_poll_clr, w_app_next;

  assign w_r1 = {7'b0, ~r_card_ready};

  always_comb begin
    w_q         = {8{8'hFF}};
    w_q[1]      = w_r1 | 8'h04;   // illegal command unless overridden below
    w_q_len     = 3'd2;
    w_is_read   = 1'b0;
    w_set_ready = 1'b0;
    w_clr_ready = 1'b0;
    w_poll_inc  = 1'b0;
    w_poll_clr  = 1'b0;
    w_app_next  = 1'b0;
    case (w_cmd_idx)
      6'd0: begin
        w_q[1]      = 8'h01;
        w_clr_ready = 1'b1;
        w_poll_clr  = 1'b1;
      end
      6'd8: begin
        w_q[1]  = w_r1;
        w_q[2]  = 8'h00;
        w_q[3]  = 8'h00;
        w_q[4]  = {4'h0, w_cmd_arg[11:8]};
        w_q[5]  = w_cmd_arg[7:0];
        w_q_len = 3'd6;
      end
      6'd55: begin
        w_q[1]     = w_r1;
        w_app_next = 1'b1;
      end
      6'd41: begin
        if (r_app) begin
          if (r_poll < c_idle_polls) begin
            w_q[1]     = 8'h01;
            w_poll_inc = 1'b1;
          end else begin
            w_q[1]      = 8'h00;
            w_set_ready = 1'b1;
          end
        end
      end
      6'd58: begin
        w_q[1]  = w_r1;
        w_q[2]  = OCR[31:24];
        w_q[3]  = OCR[23:16];
        w_q[4]  = OCR[15:8];
        w_q[5]  = OCR[7:0];
        w_q_len = 3'd6;
      end
      6'd17: begin
        if (r_card_ready) begin
          w_q[1]    = 8'h00;
          w_q[2]    = 8'hFF;      // Nac gap before the data token
          w_q_len   = 3'd3;
          w_is_read = 1'b1;
        end else begin
          w_q[1] = 8'h05;
        end
      end
      default: ;
    endcase
  end

  // ---------------- main FSM ------------------------------------------------
  always_ff @(posedge clk_sd) begin
    if (!reset_n) begin
      r_state       <= ST_HUNT;
      r_rx_sr       <= '1;
      r_tx_sr       <= 8'hFF;
      r_bit_cnt     <= '0;
      r_byte_cnt    <= '0;
      r_q           <= {8{8'hFF}};
      r_q_len       <= '0;
      r_q_idx       <= '0;
      r_is_read     <= 1'b0;
      r_card_ready  <= 1'b0;
      r_app         <= 1'b0;
      r_poll        <= '0;
      r_frame_done  <= 1'b0;
      r_cmd_valid   <= 1'b0;
      r_cmd_index   <= '0;
      r_cmd_arg     <= '0;
      r_rd_sec_addr <= '0;
      r_rd_req      <= 1'b0;
      r_rd_req_d    <= 1'b0;
      r_rd_byte_idx <= '0;
      r_hold        <= '0;
    end else begin
      r_frame_done <= 1'b0;
      r_cmd_valid  <= r_frame_done;
      r_rd_req     <= 1'b0;
      r_rd_req_d   <= r_rd_req;
      if (r_rd_req_d) r_hold <= bus.rd_data;

      if (w_cs_high) begin
        r_state    <= ST_HUNT;
        r_rx_sr    <= '1;
        r_tx_sr    <= 8'hFF;
        r_bit_cnt  <= '0;
        r_byte_cnt <= '0;
        r_q_idx    <= '0;
      end else begin
        case (r_state)
          ST_HUNT: begin
            if (w_sck_rise) begin
              r_rx_sr <= w_frame;
              // start bit 0 followed by transmission bit 1
              if ({r_rx_sr[0], w_mosi} == 2'b01) begin
                r_state   <= ST_CMD;
                r_bit_cnt <= 6'd2;
              end
            end
          end

          ST_CMD: begin
            if (w_sck_rise) begin
              r_rx_sr <= w_frame;
              if (r_bit_cnt == 6'd47) begin
                r_cmd_index  <= w_cmd_idx;
                r_cmd_arg    <= w_cmd_arg;
                r_frame_done <= 1'b1;
                r_q          <= w_q;
                r_q_len      <= w_q_len;
                r_q_idx      <= '0;
                r_is_read    <= w_is_read;
                r_app        <= w_app_next;
                if (w_set_ready) r_card_ready <= 1'b1;
                if (w_clr_ready) r_card_ready <= 1'b0;
                if (w_poll_clr)  r_poll <= '0;
                if (w_poll_inc)  r_poll <= r_poll + 8'd1;
                if (w_is_read)   r_rd_sec_addr <= w_cmd_arg;
                r_bit_cnt    <= 6'd7;   // first falling edge is a byte boundary
                r_state      <= ST_RESP;
              end else begin
                r_bit_cnt <= r_bit_cnt + 6'd1;
              end
            end
          end

          default: begin
            if (w_sck_fall) begin
              if (r_bit_cnt != 6'd7) begin
                r_tx_sr   <= {r_tx_sr[6:0], 1'b1};
                r_bit_cnt <= r_bit_cnt + 6'd1;
              end else begin
                r_bit_cnt <= '0;
                case (r_state)
                  ST_RESP: begin
                    if (r_q_idx == r_q_len) begin
                      r_tx_sr <= 8'hFF;
                      r_rx_sr <= '1;
                      r_state <= ST_HUNT;
                    end else begin
                      r_tx_sr <= r_q[r_q_idx];
                      r_q_idx <= r_q_idx + 3'd1;
                      if (r_is_read && (r_q_idx == r_q_len - 3'd1))
                        r_state <= ST_TOKEN;
                    end
                  end
                  ST_TOKEN: begin
                    r_tx_sr       <= 8'hFE;
                    r_rd_req      <= 1'b1;
                    r_rd_byte_idx <= '0;
                    r_byte_cnt    <= '0;
                    r_state       <= ST_DATA;
                  end
                  ST_DATA: begin
                    r_tx_sr <= r_hold;
                    if (r_byte_cnt == 9'd511) begin
                      r_q_idx <= '0;
                      r_state <= ST_CRC;
                    end else begin
                      // fetch the next byte while this one shifts out
                      r_rd_req      <= 1'b1;
                      r_rd_byte_idx <= r_byte_cnt + 9'd1;
                      r_byte_cnt    <= r_byte_cnt + 9'd1;
                    end
                  end
                  ST_CRC: begin
                    r_tx_sr <= 8'hFF;
                    if (r_q_idx == 3'd2) begin
                      r_rx_sr <= '1;
                      r_state <= ST_HUNT;
                    end else begin
                      r_q_idx <= r_q_idx + 3'd1;
                    end
                  end
                  default: begin
                    r_tx_sr <= 8'hFF;
                    r_state <= ST_HUNT;
                  end
                endcase
              end
            end
          end
        endcase
      end
    end
  end

  assign bus.sd_spi_miso = r_tx_sr[7];
  assign bus.card_ready  = r_card_ready;
  assign bus.cmd_valid   = r_cmd_valid;
  assign bus.cmd_index   = r_cmd_index;
  assign bus.cmd_arg     = r_cmd_arg;
  assign bus.rd_sec_addr = r_rd_sec_addr;
  assign bus.rd_req      = r_rd_req;
  assign bus.rd_byte_idx = r_rd_byte_idx;

endmodule
`default_nettype wire

// File: tb/tb_sd_spi_card_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sd_spi_card_responder
//  Description : Directed self-checking bench for sd_spi_card_responder.
//                Acts as SPI host and as the backing store (returns idx[7:0]).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_spi_card_responder;

  localparam int HALF = 4;   // SCK half period in clk_sd cycles

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  sd_spi_card_responder_if bus ();

  sd_spi_card_responder #(
    .IDLE_POLLS (2),
    .OCR        (32'hC0FF8000)
  ) dut (
    .clk_sd  (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_frames = 0;

  // monitor results
  int         n_valid    = 0;
  logic [5:0] last_idx   = '0;
  int         n_req      = 0;
  int         req_b2b    = 0;
  int         req_seqerr = 0;
  logic       prev_req   = 1'b0;
  logic [8:0] prev_ridx  = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // backing store and monitors
  always @(negedge clk) begin
    if (bus.cmd_valid) begin
      n_valid++;
      last_idx = bus.cmd_index;
    end
    if (bus.rd_req) begin
      n_req++;
      if (prev_req) req_b2b++;
      if (bus.rd_byte_idx != 9'd0 && bus.rd_byte_idx != prev_ridx + 9'd1) req_seqerr++;
      prev_ridx   = bus.rd_byte_idx;
      bus.rd_data = bus.rd_byte_idx[7:0];
    end
    prev_req = bus.rd_req;
  end

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      bus.sd_spi_mosi = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i] = bus.sd_spi_miso;
      bus.sd_spi_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.sd_spi_clk = 1'b0;
    end
  endtask

  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
    logic [7:0] rx;
    xfer({2'b01, idx}, rx);
    xfer(arg[31:24], rx);
    xfer(arg[23:16], rx);
    xfer(arg[15:8], rx);
    xfer(arg[7:0], rx);
    xfer(crc, rx);
    n_frames++;
  endtask

  // read n bytes; byte j is expected at exp[(n-1-j)*8 +: 8]
  task automatic resp_chk(input string tag, input int n, input logic [47:0] exp);
    logic [7:0] rx;
    for (int j = 0; j < n; j++) begin
      xfer(8'hFF, rx);
      chk($sformatf("%s[%0d]", tag, j), {24'h0, rx}, {24'h0, exp[(n-1-j)*8 +: 8]});
    end
  endtask

  initial begin
    logic [7:0] rx;
    int         derr;
    int         req_at_abort;

    reset_n         = 1'b0;
    bus.sd_spi_clk  = 1'b0;
    bus.sd_spi_cs   = 1'b1;
    bus.sd_spi_mosi = 1'b1;
    repeat (5) @(negedge clk);

    chk("rst_miso",     {31'h0, bus.sd_spi_miso}, 32'h1);
    chk("rst_ready",    {31'h0, bus.card_ready},  32'h0);
    chk("rst_cmdvalid", {31'h0, bus.cmd_valid},   32'h0);
    chk("rst_rdreq",    {31'h0, bus.rd_req},      32'h0);
    chk("rst_cmdidx",   {26'h0, bus.cmd_index},   32'h0);
    chk("rst_cmdarg",   bus.cmd_arg,              32'h0);
    chk("rst_secaddr",  bus.rd_sec_addr,          32'h0);
    chk("rst_byteidx",  {23'h0, bus.rd_byte_idx}, 32'h0);

    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    bus.sd_spi_cs = 1'b0;
    repeat (8) @(negedge clk);

    // CMD0
    send_cmd(6'd0, 32'h0, 8'h95);
    resp_chk("cmd0", 2, 48'hFF01);
    chk("cmd0_valid_cnt", n_valid, 32'd1);
    chk("cmd0_idx", {26'h0, last_idx}, 32'd0);

    // CMD41 without CMD55 -> illegal, idle
    send_cmd(6'd41, 32'h0, 8'hFF);
    resp_chk("cmd41_noapp", 2, 48'hFF05);

    // CMD17 before ready
    send_cmd(6'd17, 32'h0, 8'hFF);
    resp_chk("cmd17_notready", 2, 48'hFF05);
    chk("cmd17_notready_req", n_req, 32'd0);

    // CMD8
    send_cmd(6'd8, 32'h000001AA, 8'h87);
    resp_chk("cmd8", 6, 48'hFF01_0000_01AA);
    chk("cmd8_arg", bus.cmd_arg, 32'h000001AA);

    // CMD55 + ACMD41 x3
    send_cmd(6'd55, 32'h0, 8'hFF); resp_chk("cmd55_a", 2, 48'hFF01);
    send_cmd(6'd41, 32'h40000000, 8'hFF); resp_chk("acmd41_a", 2, 48'hFF01);
    chk("ready_a", {31'h0, bus.card_ready}, 32'h0);
    send_cmd(6'd55, 32'h0, 8'hFF); resp_chk("cmd55_b", 2, 48'hFF01);
    send_cmd(6'd41, 32'h40000000, 8'hFF); resp_chk("acmd41_b", 2, 48'hFF01);
    chk("ready_b", {31'h0, bus.card_ready}, 32'h0);
    send_cmd(6'd55, 32'h0, 8'hFF); resp_chk("cmd55_c", 2, 48'hFF01);
    send_cmd(6'd41, 32'h40000000, 8'hFF); resp_chk("acmd41_c", 2, 48'hFF00);
    chk("ready_c", {31'h0, bus.card_ready}, 32'h1);

    // CMD58
    send_cmd(6'd58, 32'h0, 8'hFF);
    resp_chk("cmd58", 6, 48'hFF00_C0FF_8000);

    // CMD13 after ready -> illegal, not idle
    send_cmd(6'd13, 32'h0, 8'hFF);
    resp_chk("cmd13", 2, 48'hFF04);

    // CMD17 full block read
    send_cmd(6'd17, 32'h00000010, 8'hFF);
    resp_chk("cmd17_hdr", 4, 48'hFF00_FFFE);
    derr = 0;
    for (int k = 0; k < 512; k++) begin
      xfer(8'hFF, rx);
      if (rx != 8'(k)) derr++;
    end
    chk("cmd17_data_errs", derr, 32'd0);
    resp_chk("cmd17_tail", 3, 48'hFF_FFFF);
    chk("cmd17_nreq",    n_req,          32'd512);
    chk("cmd17_secaddr", bus.rd_sec_addr, 32'h10);
    chk("cmd17_idx",     {26'h0, bus.cmd_index}, 32'd17);
    chk("rdreq_b2b",     req_b2b,        32'd0);
    chk("rdreq_seq",     req_seqerr,     32'd0);

    // CMD17 aborted by CS at data byte 100
    send_cmd(6'd17, 32'h00000020, 8'hFF);
    resp_chk("abort_hdr", 4, 48'hFF00_FFFE);
    for (int k = 0; k < 100; k++) xfer(8'hFF, rx);
    repeat (4) @(negedge clk);
    chk("abort_miso_before", {31'h0, bus.sd_spi_miso}, 32'h0);   // 0x64 MSB
    bus.sd_spi_cs = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("abort_miso", {31'h0, bus.sd_spi_miso}, 32'h1);
    req_at_abort = n_req;
    chk("abort_nreq", req_at_abort, 32'd614);   // 512 + token + loads of bytes 0..100
    for (int i = 0; i < 8; i++) begin
      bus.sd_spi_clk = 1'b1; repeat (HALF) @(negedge clk);
      bus.sd_spi_clk = 1'b0; repeat (HALF) @(negedge clk);
    end
    chk("abort_req_stop", n_req, req_at_abort);
    chk("abort_miso_idle", {31'h0, bus.sd_spi_miso}, 32'h1);
    bus.sd_spi_cs = 1'b0;
    repeat (8) @(negedge clk);

    send_cmd(6'd58, 32'h0, 8'hFF);
    resp_chk("post_abort_cmd58", 6, 48'hFF00_C0FF_8000);
    chk("post_abort_ready", {31'h0, bus.card_ready}, 32'h1);

    repeat (10) @(negedge clk);
    chk("cmd_valid_total", n_valid, n_frames);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/sd_spi_card_responder.md
# sd_spi_card_responder

SPI-mode SD card responder: the card-side end of the SD SPI link driven by the host controller. It decodes 48-bit command frames on `sd_spi_mosi` and returns R1/R3/R7 responses, plus single-block read data (CMD17) fetched byte-by-byte from a backing-store interface. It serves as the synthesizable card model in system benches and as an on-board SD emulator for host bring-up. All SPI pins are oversampled in the `clk_sd` domain; nothing is clocked by `sd_spi_clk`.

## Interface
- `IDLE_POLLS`, default 2: number of ACMD41 responses with the idle bit set before the card reports ready.
- `OCR`, default 32'hC0FF8000: OCR value returned by CMD58.
- `clk_sd`, in, 1: sole clock.
- `reset_n`, in, 1: reset, synchronous, active-low.
- `sd_spi_clk`, in, 1: host SCK, asynchronous, SPI mode 0.
- `sd_spi_cs`, in, 1: chip select, asynchronous, active-low.
- `sd_spi_mosi`, in, 1: host to card data, asynchronous.
- `sd_spi_miso`, out, 1: card to host data, registered, MSB first.
- `card_ready`, out, 1: set by a successful ACMD41; cleared by CMD0.
- `cmd_valid`, out, 1: one-cycle pulse per decoded command frame.
- `cmd_index`, out, 6: index of the last command; held until the next frame.
- `cmd_arg`, out, 32: argument of the last command; held until the next frame.
- `rd_sec_addr`, out, 32: sector address of the active CMD17; equals `cmd_arg`.
- `rd_req`, out, 1: one-cycle byte fetch strobe.
- `rd_byte_idx`, out, 9: index of the requested byte, 0..511.
- `rd_data`, in, 8: requested byte; valid exactly 1 cycle after `rd_req`.

## Operation
- **Input synchronisation.** SCK, CS and MOSI each pass through 2 sync flops. Rising and falling SCK edges are detected from the synchronised copies.
- **Mode 0 timing.** MOSI is sampled on the rising SCK edge. MISO changes on the falling SCK edge.
- **CS high.** At any time, CS high forces state HUNT, clears all bit and byte counters, drives `sd_spi_miso`=1 and drops any read in progress. `card_ready`, the app flag and the poll counter are retained.
- **States:** HUNT → CMD → RESP → (TOKEN → DATA → CRC) → HUNT.
- **HUNT.**
  - Shift MOSI on rising edges.
  - A frame starts on a received 0 followed by a 1 (start bit, transmission bit).
  - Go to CMD with 2 of the 48 bits received.
- **CMD.**
  - Receive the remaining 46 bits.
  - Bits [45:40] are the index and [39:8] the argument.
  - CRC and the end bit are ignored.
  - On the 48th rising edge: latch index/arg, pulse `cmd_valid` on the next cycle, build the response queue, go to RESP.
- **Response queue, R1 = {7'b0, idle}, idle = !card_ready:**
  - CMD0: 0x01. Clears `card_ready` and the poll counter.
  - CMD8: R1, 0x00, 0x00, {4'h0,arg[11:8]}, arg[7:0].
  - CMD55: R1. Sets the app flag.
  - ACMD41 (CMD41 with the app flag set):
    - Poll counter < IDLE_POLLS: response 0x01, counter increments.
    - Otherwise: response 0x00 and `card_ready` sets.
  - CMD58: R1, then OCR[31:24], [23:16], [15:8], [7:0].
  - CMD17 with `card_ready`=1: 0x00, then TOKEN. With `card_ready`=0: 0x05 only.
  - Any other command, or CMD41 without the app flag: R1 | 0x04.
  - The app flag clears on every command except CMD55.
- **TX engine.**
  - `sd_spi_miso` = tx_sr[7].
  - On the falling edge after the 48th rising edge, load filler 0xFF (Ncr = 1 byte).
  - 7 further falling edges shift tx_sr left.
  - The 8th falling edge loads the next queued byte.
  - After the last byte has shifted out, the next falling edge loads 0xFF and the state returns to HUNT. MOSI is ignored outside HUNT/CMD.
- **CMD17 data phase.**
  - After R1: one 0xFF (Nac), then token 0xFE.
  - Then 512 data bytes (idx 0..511), then CRC bytes 0xFF, 0xFF.
- **Data prefetch.**
  - On loading the token, pulse `rd_req` with idx 0.
  - On loading data byte k (k<511), pulse `rd_req` with idx k+1.
  - `rd_data` is captured into a holding register 1 cycle after `rd_req`.

## Timing
- **Reset values:**
  - `sd_spi_miso`=1.
  - `card_ready`, `cmd_valid`, `rd_req` = 0.
  - `cmd_index`, `cmd_arg`, `rd_sec_addr`, `rd_byte_idx` = 0.
  - State HUNT, app flag 0, poll counter 0.
- **SCK phases.** Each SCK high and low phase must be ≥ 4 `clk_sd` cycles.
- **MISO latency.** `sd_spi_miso` updates 3 cycles after an SCK pin falling edge (2 sync + 1 register).
- **`cmd_valid` latency.** `cmd_valid` pulses 4 cycles after the 48th SCK pin rising edge.
- **Read handshake.**
  - `rd_req` is 1 cycle wide and never asserted on consecutive cycles.
  - `rd_data` is sampled on cycle `rd_req`+1.
  - This leaves ≥ 7 SCK phases of margin before use.
- **Reset mid-frame.** Same result as reset at any time: all outputs return to reset values on the next edge.

## Test plan
- **Init sequence.** CMD0 (0x40 00000000 95) → 0xFF, then 0x01; `cmd_valid` with idx 0.
- **CMD8.** CMD8 arg 0x000001AA → R7 bytes 01 00 00 01 AA.
- **ACMD41 polling (IDLE_POLLS=2).** CMD55+ACMD41 sent 3 times:
  - R1 responses 01, 01, 00.
  - `card_ready` rises after the third ACMD41.
  - CMD58 → 00 C0 FF 80 00.
- **CMD17 read.** `card_ready`=1, CMD17 arg 0x00000010, backing store returns idx[7:0]:
  - MISO: FF 00 FF FE 00 01 .. FF FF FF.
  - 512 `rd_req` pulses; `rd_sec_addr`=0x10.
- **Error responses.**
  - CMD17 before ready → 0x05.
  - CMD41 without CMD55 → 0x05 (idle).
  - CMD13 after ready → 0x04.
- **Abort.** CS deasserted at data byte 100 of CMD17:
  - MISO=1 within 3 cycles; `rd_req` stops.
  - Next CMD58 responds normally; `card_ready` stays 1.
